// File: rtl/evt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : evt_arbiter
// Description : Round-robin arbiter funnelling NUM_INPUTS event sources into
//               one registered, source-tagged stream with per-port counters.
// Revision    : 1.0 - initial release
// ============================================================================
module evt_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_BITS   = 2,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           evt_data_in [NUM_INPUTS-1:0],
    input  logic [NUM_INPUTS-1:0] evt_vld_in,
    output logic [NUM_INPUTS-1:0] evt_rdy_out,
    input  logic [NUM_INPUTS-1:0] port_en_in,
    input  logic                  cnt_clr_in,
    output logic [CNT_BITS-1:0]   evt_cnt_out [NUM_INPUTS-1:0],
    output logic [31:0]           evt_data_out,
    output logic [IDX_BITS-1:0]   evt_src_out,
    output logic                  evt_vld_out,
    input  logic                  evt_rdy_in
);

    localparam int c_IDX_W = IDX_BITS + 1;

    logic [IDX_BITS-1:0]   ptr_q, ptr_d;
    logic [31:0]           data_q, data_d;
    logic [IDX_BITS-1:0]   src_q, src_d;
    logic                  vld_q, vld_d;
    logic [CNT_BITS-1:0]   cnt_q [NUM_INPUTS-1:0];
    logic [CNT_BITS-1:0]   cnt_d [NUM_INPUTS-1:0];

    logic [NUM_INPUTS-1:0] w_req;
    logic                  w_any;
    logic                  w_can_load;
    logic                  w_xfer;
    logic [IDX_BITS-1:0]   w_winner;
    logic [c_IDX_W-1:0]    w_idx;
    logic [NUM_INPUTS-1:0] w_rdy;

    assign w_req      = evt_vld_in & port_en_in;
    assign w_any      = |w_req;
    assign w_can_load = !vld_q || evt_rdy_in;
    assign w_xfer     = reset_n && w_can_load && w_any;

    // Rotating search starting at ptr_q; wrap done explicitly so any NUM_INPUTS works.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr_q} + c_IDX_W'(k);
            if (w_idx >= c_IDX_W'(NUM_INPUTS))
                w_idx = w_idx - c_IDX_W'(NUM_INPUTS);
            if (w_req[w_idx[IDX_BITS-1:0]])
                w_winner = w_idx[IDX_BITS-1:0];
        end
    end

    always_comb begin
        w_rdy = '0;
        if (w_xfer)
            w_rdy[w_winner] = 1'b1;
    end

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        src_d  = src_q;
        vld_d  = vld_q;
        if (w_xfer) begin
            data_d = evt_data_in[w_winner];
            src_d  = w_winner;
            vld_d  = 1'b1;
            if (w_winner == IDX_BITS'(NUM_INPUTS - 1))
                ptr_d = '0;
            else
                ptr_d = w_winner + IDX_BITS'(1);
        end else if (evt_rdy_in) begin
            vld_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr_in)
                cnt_d[i] = '0;
            else if (w_xfer && (w_winner == IDX_BITS'(i)) && (cnt_q[i] != {CNT_BITS{1'b1}}))
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= '0;
            data_q <= '0;
            src_q  <= '0;
            vld_q  <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++)
                cnt_q[i] <= '0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            src_q  <= src_d;
            vld_q  <= vld_d;
            for (int i = 0; i < NUM_INPUTS; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign evt_rdy_out  = w_rdy;
    assign evt_data_out = data_q;
    assign evt_src_out  = src_q;
    assign evt_vld_out  = vld_q;
    assign evt_cnt_out  = cnt_q;

endmodule
`default_nettype wire

// File: doc/evt_arbiter.md
Name: evt_arbiter

Overview:
Round-robin arbiter that shares one pkt_assembler event input among NUM_INPUTS independent event sources, for example multiple peripheral input pipes. It drives a single registered event stream with a source tag, which downstream logic uses to select per-source mapper configuration. It also keeps per-source accepted-event counters for the register bank.

Parameters:
NUM_INPUTS, 4, number of requesting event ports (2..8)
IDX_BITS, 2, width of source index; must equal ceil(log2(NUM_INPUTS)), minimum 1
CNT_BITS, 16, width of per-port accepted-event counters

Ports:
clk  in  1  block clock
reset_n  in  1  asynchronous active-low reset
evt_data_in  in  32 x NUM_INPUTS  per-port event data (unpacked array [NUM_INPUTS-1:0])
evt_vld_in  in  NUM_INPUTS  per-port valid
evt_rdy_out  out  NUM_INPUTS  per-port ready (combinational grant)
port_en_in  in  NUM_INPUTS  per-port enable from config registers
cnt_clr_in  in  1  synchronous clear of all counters
evt_cnt_out  out  CNT_BITS x NUM_INPUTS  per-port accepted-event count (unpacked array)
evt_data_out  out  32  arbitrated event data
evt_src_out  out  IDX_BITS  index of source port of evt_data_out
evt_vld_out  out  1  output valid
evt_rdy_in  in  1  output ready (from pkt_assembler evt_rdy_out)

Behaviour:
- Reset (reset_n low, async): evt_vld_out=0, evt_data_out=0, evt_src_out=0, rr pointer=0, all evt_cnt_out=0. evt_rdy_out=0 while reset_n low. Any event held in the output register is discarded.
- Candidate set: req[i] = evt_vld_in[i] & port_en_in[i].
- can_load = !evt_vld_out | evt_rdy_in. The output register is empty or is being consumed this cycle.
- Winner: first i with req[i]=1, searching ptr, ptr+1, …, wrapping modulo NUM_INPUTS. ptr itself has highest priority.
- evt_rdy_out[i] = can_load & any(req) & (i == winner). At most one bit is set. It is 0 for disabled ports, even if valid.
- Transfer on port i when evt_vld_in[i] & evt_rdy_out[i]. Registered output: next cycle evt_data_out=evt_data_in[winner], evt_src_out=winner, evt_vld_out=1. Latency is 1 clk.
- On transfer: ptr <= (winner+1) mod NUM_INPUTS. The wrap is explicit, not a power-of-2 overflow, so non-power-of-2 NUM_INPUTS works. ptr does not change on cycles without a transfer.
- If can_load=1 and no request: evt_vld_out <= 0 when evt_rdy_in consumed the current event; otherwise it holds.
- Backpressure: while evt_vld_out=1 and evt_rdy_in=0, evt_data_out and evt_src_out are stable and all evt_rdy_out are 0.
- Throughput: one event per clk when evt_rdy_in stays high.
- Upstream evt_vld_in must not depend combinationally on evt_rdy_out. Upstream must hold data and valid until ready.
- Enable changes: port_en_in is sampled combinationally each cycle. Deasserting it stalls that port without data loss. An event already in the output register is unaffected.
- Counters: evt_cnt_out[i] increments by 1 on each transfer from port i and saturates at all-ones (no wrap).
  - cnt_clr_in=1 sets all counters to 0. It has priority over a same-cycle increment; that event is not counted.
- No internal state other than ptr, the output register and the counters. Reset mid-transfer returns the block to idle with the pointer at 0.

Test Plan:
1. Port 1 only, enabled, 8 events 0x100..0x107, evt_rdy_in=1 → out 0x100..0x107 on consecutive clks, evt_src_out=1, first valid 1 clk after the first transfer; evt_cnt_out[1]=8.
2. All 4 ports continuously valid (data 0xA0+i), evt_rdy_in=1 → evt_src_out sequence 0,1,2,3,0,1,…; after 400 clks each count is 100 (±1).
3. Port 2 valid with 0xDEAD_BEEF, evt_rdy_in held 0 for 5 clks after the first event → evt_data_out is stable, all evt_rdy_out=0 during the stall; the next event transfers in the cycle evt_rdy_in rises.
4. port_en_in=4'b1011, all valid → port 2 never granted, sequence 0,1,3,0,…; re-enable port 2 mid-stream → its held event appears within 4 grants.
5. CNT_BITS=4, port 0 sends 20 events → evt_cnt_out[0]=15 (saturated); cnt_clr_in pulse coincident with a transfer → count 0.
6. reset_n low for 1 clk while evt_vld_out=1 and ptr=2 → immediately evt_vld_out=0 and counters 0; after release, with ports 0 and 3 valid, port 0 is granted first.
